// File: rtl/pb_press_decoder_if.sv
// Button-to-decoder bundle: debounced level and edge pulses in, press events out.
interface pb_press_decoder_if;
  logic btn_state;
  logic btn_down;
  logic btn_up;
  logic short_press;
  logic long_press;
  logic repeat_tick;
  logic held;

  modport master (
    output btn_state, btn_down, btn_up,
    input  short_press, long_press, repeat_tick, held
  );

  modport slave (
    input  btn_state, btn_down, btn_up,
    output short_press, long_press, repeat_tick, held
  );
endinterface

// File: rtl/pb_press_decoder.sv
// Classifies debounced button presses into tap / long-press / auto-repeat pulses, all registered.
// Auto-repeat is built only when PB_PRESS_DECODER_REPEAT_EN is defined; otherwise repeat_tick is tied 0.
module pb_press_decoder #(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int CNT_W         = 27
) (
  input  logic             clk,
  input  logic             rst,
  pb_press_decoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;

  // The counter reads 0 in the first PRESS cycle, so the long decision is taken at
  // LONG_CYCLES-2 and its registered pulse lands LONG_CYCLES cycles after btn_down.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             held_q, held_d;

`ifdef PB_PRESS_DECODER_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic rep_q, rep_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    long_d  = 1'b0;
`ifdef PB_PRESS_DECODER_REPEAT_EN
    rep_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.btn_down && !bus.btn_up) begin
          state_d = PRESS;
          cnt_d   = '0;
        end
      end
      PRESS: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.btn_up) begin
          state_d = IDLE;
          cnt_d   = '0;
          short_d = 1'b1;
        end else if (!bus.btn_state) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end
      end
      LONG: begin
        if (bus.btn_up || !bus.btn_state) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
`ifdef PB_PRESS_DECODER_REPEAT_EN
          if (cnt_q == REP_LAST) begin
            cnt_d = '0;
            rep_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      held_q  <= held_d;
    end
  end

`ifdef PB_PRESS_DECODER_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) rep_q <= 1'b0;
    else     rep_q <= rep_d;
  end
  assign bus.repeat_tick = rep_q;
`else
  assign bus.repeat_tick = 1'b0;
`endif

  assign bus.short_press = short_q;
  assign bus.long_press  = long_q;
  assign bus.held        = held_q;

endmodule

// File: tb/tb_pb_press_decoder.sv
// Directed scenarios for pb_press_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4.
module tb_pb_press_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pb_press_decoder_if bus ();

  pb_press_decoder #(
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    rst           = 1'b0;
    bus.btn_state = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_up    = 1'b0;
  endtask

  // Cycle c: inputs are applied during c and sampled on its closing edge;
  // outputs observed in cycle c were registered on the edge that opened it.
  task automatic run_scenario(input int id, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      logic e_short, e_long, e_rep, e_held;
      drive_idle();
      e_short = 1'b0;
      e_long  = 1'b0;
      e_rep   = 1'b0;
      e_held  = 1'b0;
      case (id)
        0: begin // tap
          bus.btn_down  = (c == 0);
          bus.btn_state = (c <= 2);
          bus.btn_up    = (c == 3);
          e_held  = (c >= 1 && c <= 3);
          e_short = (c == 4);
        end
        1: begin // hold with release on the cycle a third tick would be decided
          bus.btn_down  = (c == 0);
          bus.btn_state = (c <= 18);
          bus.btn_up    = (c == 19);
          e_held = (c >= 1 && c <= 19);
          e_long = (c == 8);
`ifdef PB_PRESS_DECODER_REPEAT_EN
          e_rep  = (c == 12 || c == 16);
`endif
        end
        2: begin // release on the threshold cycle
          bus.btn_down  = (c == 0);
          bus.btn_state = (c <= 6);
          bus.btn_up    = (c == 7);
          e_held  = (c >= 1 && c <= 7);
          e_short = (c == 8);
        end
        3: begin // level lost without an up pulse
          bus.btn_down  = (c == 0);
          bus.btn_state = (c <= 1);
          e_held = (c >= 1 && c <= 2);
        end
        4: begin // reset while held
          bus.btn_down  = (c == 0);
          bus.btn_state = (c <= 12);
          rst           = (c == 5);
          e_held = (c >= 1 && c <= 5);
        end
        5: begin // repeated down during press, then down+up together in IDLE
          bus.btn_down  = (c == 0 || c == 4 || c == 14);
          bus.btn_state = (c <= 9);
          bus.btn_up    = (c == 10 || c == 14);
          e_held = (c >= 1 && c <= 10);
          e_long = (c == 8);
        end
        default: ;
      endcase
      @(negedge clk);
      expect_eq($sformatf("s%0d c%0d short_press", id, c), 32'(bus.short_press), 32'(e_short));
      expect_eq($sformatf("s%0d c%0d long_press",  id, c), 32'(bus.long_press),  32'(e_long));
      expect_eq($sformatf("s%0d c%0d repeat_tick", id, c), 32'(bus.repeat_tick), 32'(e_rep));
      expect_eq($sformatf("s%0d c%0d held",        id, c), 32'(bus.held),        32'(e_held));
      @(posedge clk);
      #1;
    end
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    bus.btn_state = 1'b1;
    bus.btn_down  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    expect_eq("reset short_press", 32'(bus.short_press), 32'd0);
    expect_eq("reset long_press",  32'(bus.long_press),  32'd0);
    expect_eq("reset repeat_tick", 32'(bus.repeat_tick), 32'd0);
    expect_eq("reset held",        32'(bus.held),        32'd0);
    drive_idle();
    @(posedge clk);
    #1;

    run_scenario(0, 8);
    run_scenario(1, 24);
    run_scenario(2, 12);
    run_scenario(3, 12);
    run_scenario(4, 14);
    run_scenario(5, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
